path_verifier: RTL and testbench

PATH_VERIFIER -- requirements
Module: path_verifier

---
 rtl/path_verifier.sv | 168 ++++++++++++++++
 tb/tb_path_verifier.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/path_verifier.sv
// Maze path verifier: replays a stream of moves from (0,0) against a wall map
// held in external memory and reports pass or the first error encountered.
module path_verifier (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       dir_valid,
    input  logic [1:0] dir,
    input  logic       dir_last,
    output logic       dir_ready,
    output logic       mem_rd,
    output logic [3:0] mem_x,
    output logic [3:0] mem_y,
    input  logic       mem_dout,
    output logic [3:0] cur_x,
    output logic [3:0] cur_y,
    output logic [7:0] step_count,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic       err_wall,
    output logic       err_range,
    output logic       err_short,
    output logic       err_overrun
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WAIT = 3'd1,
        RD   = 3'd2,
        EVAL = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [3:0]  cur_x_r;
    logic [3:0]  cur_y_r;
    logic [3:0]  tgt_x_r;
    logic [3:0]  tgt_y_r;
    logic        last_r;
    logic [7:0]  step_r;
    logic        pass_r;
    logic        err_wall_r;
    logic        err_range_r;
    logic        err_short_r;
    logic        err_overrun_r;

    logic        accept_s;
    logic [4:0]  tx_s;
    logic [4:0]  ty_s;
    logic        out_of_range_s;
    logic        at_goal_s;
    logic        restart_s;

    assign accept_s  = (state_r == WAIT) && dir_valid;
    assign at_goal_s = (tgt_x_r == 4'hF) && (tgt_y_r == 4'hF);
    assign restart_s = start && ((state_r == IDLE) || (state_r == DONE));

    // Target cell in 5-bit arithmetic; bit 4 flags leaving the 0..15 grid either way.
    always_comb begin
        tx_s = {1'b0, cur_x_r};
        ty_s = {1'b0, cur_y_r};
        case (dir)
            2'b00:   ty_s = {1'b0, cur_y_r} - 5'd1;
            2'b01:   tx_s = {1'b0, cur_x_r} + 5'd1;
            2'b10:   tx_s = {1'b0, cur_x_r} - 5'd1;
            2'b11:   ty_s = {1'b0, cur_y_r} + 5'd1;
            default: tx_s = {1'b0, cur_x_r};
        endcase
        out_of_range_s = tx_s[4] | ty_s[4];
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) state_r <= IDLE;
        else      state_r <= state_s;
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: if (start) state_s = WAIT; else state_s = IDLE;
            WAIT: begin
                if (accept_s) state_s = out_of_range_s ? DONE : RD;
                else          state_s = WAIT;
            end
            RD:   state_s = EVAL;
            EVAL: begin
                if (mem_dout || at_goal_s || last_r) state_s = DONE;
                else                                 state_s = WAIT;
            end
            DONE: if (start) state_s = WAIT; else state_s = DONE;
            default: state_s = IDLE;
        endcase
    end

    // Output decode from the state register.
    always_comb begin
        dir_ready = (state_r == WAIT);
        mem_rd    = (state_r == RD);
        busy      = (state_r == WAIT) || (state_r == RD) || (state_r == EVAL);
        done      = (state_r == DONE);
        if (state_r == RD) begin
            mem_x = tgt_x_r;
            mem_y = tgt_y_r;
        end else begin
            mem_x = cur_x_r;
            mem_y = cur_y_r;
        end
    end

    // Position, step counter and result flags.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cur_x_r       <= 4'd0;
            cur_y_r       <= 4'd0;
            tgt_x_r       <= 4'd0;
            tgt_y_r       <= 4'd0;
            last_r        <= 1'b0;
            step_r        <= 8'd0;
            pass_r        <= 1'b0;
            err_wall_r    <= 1'b0;
            err_range_r   <= 1'b0;
            err_short_r   <= 1'b0;
            err_overrun_r <= 1'b0;
        end else if (restart_s) begin
            cur_x_r       <= 4'd0;
            cur_y_r       <= 4'd0;
            step_r        <= 8'd0;
            pass_r        <= 1'b0;
            err_wall_r    <= 1'b0;
            err_range_r   <= 1'b0;
            err_short_r   <= 1'b0;
            err_overrun_r <= 1'b0;
        end else if (accept_s) begin
            tgt_x_r <= tx_s[3:0];
            tgt_y_r <= ty_s[3:0];
            last_r  <= dir_last;
            if (out_of_range_s) err_range_r <= 1'b1;
        end else if (state_r == EVAL) begin
            if (mem_dout) begin
                err_wall_r <= 1'b1;
            end else begin
                cur_x_r <= tgt_x_r;
                cur_y_r <= tgt_y_r;
                if (step_r != 8'hFF) step_r <= step_r + 8'd1;
                if (at_goal_s) begin
                    if (last_r) pass_r        <= 1'b1;
                    else        err_overrun_r <= 1'b1;
                end else if (last_r) begin
                    err_short_r <= 1'b1;
                end
            end
        end
    end

    assign cur_x       = cur_x_r;
    assign cur_y       = cur_y_r;
    assign step_count  = step_r;
    assign pass        = pass_r;
    assign err_wall    = err_wall_r;
    assign err_range   = err_range_r;
    assign err_short   = err_short_r;
    assign err_overrun = err_overrun_r;

endmodule

// File: tb/tb_path_verifier.sv
// Directed bench for path_verifier with a registered 16x16 wall-map model.
module tb_path_verifier;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       dir_valid = 1'b0;
    logic [1:0] dir = 2'b00;
    logic       dir_last = 1'b0;
    logic       dir_ready, mem_rd, mem_dout;
    logic [3:0] mem_x, mem_y, cur_x, cur_y;
    logic [7:0] step_count;
    logic       busy, done, pass, err_wall, err_range, err_short, err_overrun;

    logic [15:0] wall [16];
    int tests = 0;
    int fails = 0;
    int rd_cnt = 0;
    int acc_cnt = 0;
    int rd0, acc0;
    logic [3:0] last_rd_x = 4'd0;
    logic [3:0] last_rd_y = 4'd0;

    path_verifier dut (
        .clk(clk), .rst(rst), .start(start), .dir_valid(dir_valid), .dir(dir),
        .dir_last(dir_last), .dir_ready(dir_ready), .mem_rd(mem_rd), .mem_x(mem_x),
        .mem_y(mem_y), .mem_dout(mem_dout), .cur_x(cur_x), .cur_y(cur_y),
        .step_count(step_count), .busy(busy), .done(done), .pass(pass),
        .err_wall(err_wall), .err_range(err_range), .err_short(err_short),
        .err_overrun(err_overrun)
    );

    always #5 clk = ~clk;

    initial mem_dout = 1'b0;
    always @(posedge clk) begin
        if (mem_rd) begin
            mem_dout  <= wall[mem_y][mem_x];
            rd_cnt    <= rd_cnt + 1;
            last_rd_x <= mem_x;
            last_rd_y <= mem_y;
        end
        if (dir_valid && dir_ready) acc_cnt <= acc_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] flags();
        return {pass, err_wall, err_range, err_short, err_overrun};
    endfunction

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Present one move and return at the negedge after it was accepted.
    task automatic send(input logic [1:0] d, input logic l);
        int n = 0;
        dir = d; dir_last = l; dir_valid = 1'b1;
        while (!dir_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk("accept_timeout", {31'd0, dir_ready}, 32'd1);
        @(negedge clk);
        dir_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk("done_timeout", {31'd0, done}, 32'd1);
    endtask

    task automatic full_path(input logic last_final);
        for (int i = 0; i < 15; i++) send(2'b01, 1'b0);
        for (int i = 0; i < 14; i++) send(2'b11, 1'b0);
        send(2'b11, last_final);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) wall[i] = 16'h0000;
        repeat (3) @(negedge clk);
        chk("rst_ready",  {31'd0, dir_ready}, 32'd0);
        chk("rst_memrd",  {31'd0, mem_rd}, 32'd0);
        chk("rst_busy",   {30'd0, busy, done}, 32'd0);
        chk("rst_pos",    {24'd0, cur_x, cur_y}, 32'd0);
        chk("rst_steps",  {24'd0, step_count}, 32'd0);
        chk("rst_flags",  {27'd0, flags()}, 32'd0);

        // Full legal path with latency and address checks on the first move.
        rst = 1'b1;
        rd0 = rd_cnt;
        pulse_start();
        chk("start_busy", {30'd0, busy, dir_ready}, 32'd3);
        send(2'b01, 1'b0);
        chk("rd_state",   {23'd0, mem_rd, dir_ready, mem_x, mem_y}, {23'd0, 1'b1, 1'b0, 4'd1, 4'd0});
        @(negedge clk);
        chk("eval_state", {23'd0, mem_rd, dir_ready, mem_x, mem_y}, {23'd0, 1'b0, 1'b0, 4'd0, 4'd0});
        @(negedge clk);
        chk("latency3",   {27'd0, dir_ready, cur_x}, {27'd0, 1'b1, 4'd1});
        for (int i = 0; i < 14; i++) send(2'b01, 1'b0);
        for (int i = 0; i < 14; i++) send(2'b11, 1'b0);
        send(2'b11, 1'b1);
        wait_done();
        chk("pass_flags", {27'd0, flags()}, 32'h10);
        chk("pass_pos",   {24'd0, cur_x, cur_y}, 32'hFF);
        chk("pass_steps", {24'd0, step_count}, 32'd30);
        chk("pass_rds",   rd_cnt - rd0, 32'd30);
        chk("done_addr",  {22'd0, done, busy, mem_x, mem_y}, {22'd0, 1'b1, 1'b0, 8'hFF});

        // Range error from (0,0), restarted from DONE.
        rd0 = rd_cnt;
        pulse_start();
        send(2'b00, 1'b0);
        chk("range_done",  {31'd0, done}, 32'd1);
        chk("range_flags", {27'd0, flags()}, 32'h04);
        chk("range_nord",  rd_cnt - rd0, 32'd0);
        chk("range_pos",   {16'd0, cur_x, cur_y, step_count}, 32'd0);

        // Wall at (2,0).
        wall[0][2] = 1'b1;
        pulse_start();
        send(2'b01, 1'b0);
        send(2'b01, 1'b0);
        wait_done();
        chk("wall_flags", {27'd0, flags()}, 32'h08);
        chk("wall_pos",   {16'd0, cur_x, cur_y, step_count}, {16'd0, 4'd1, 4'd0, 8'd1});
        chk("wall_addr",  {24'd0, last_rd_x, last_rd_y}, {24'd0, 4'd2, 4'd0});
        wall[0][2] = 1'b0;

        // Short path and overrun.
        pulse_start();
        send(2'b01, 1'b0);
        send(2'b01, 1'b1);
        wait_done();
        chk("short_flags", {27'd0, flags()}, 32'h02);
        chk("short_pos",   {24'd0, cur_x, cur_y}, {24'd0, 4'd2, 4'd0});
        pulse_start();
        full_path(1'b0);
        wait_done();
        chk("over_flags", {27'd0, flags()}, 32'h01);
        chk("over_pos",   {24'd0, cur_x, cur_y}, 32'hFF);

        // Step counter saturation after 256 legal moves.
        pulse_start();
        for (int i = 0; i < 128; i++) begin
            send(2'b01, 1'b0);
            send(2'b10, 1'b0);
        end
        @(negedge clk);
        @(negedge clk);
        chk("sat_steps", {24'd0, step_count}, 32'd255);
        chk("sat_busy",  {27'd0, busy, cur_x}, {27'd0, 1'b1, 4'd0});

        // Reset during RD of move 3, then first edge out of reset honours start.
        pulse_start();
        send(2'b01, 1'b0);
        send(2'b01, 1'b0);
        send(2'b01, 1'b0);
        chk("mid_rd", {31'd0, mem_rd}, 32'd1);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_ctl",  {28'd0, busy, done, dir_ready, mem_rd}, 32'd0);
        chk("mid_rst_data", {11'd0, cur_x, cur_y, step_count, flags()}, 32'd0);
        rst = 1'b1;
        pulse_start();
        chk("post_rst_start", {31'd0, busy}, 32'd1);
        full_path(1'b1);
        wait_done();
        chk("post_rst_pass", {27'd0, flags()}, 32'h10);

        // Continuous dir_valid and start pulsed while busy.
        pulse_start();
        acc0 = acc_cnt;
        dir = 2'b01; dir_last = 1'b0; dir_valid = 1'b1;
        @(negedge clk);
        start = 1'b1;
        repeat (5) @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        dir_valid = 1'b0;
        chk("hold_accepts", acc_cnt - acc0, 32'd3);
        chk("hold_pos",     {20'd0, cur_x, step_count}, {20'd0, 4'd3, 8'd3});
        chk("hold_busy",    {31'd0, busy}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
